// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with parallel load, wrap or saturate at the limits,
// and registered one-cycle overflow/underflow/load-error pulses.
module bcd_updown_counter #(
  parameter int unsigned BCD_NUM  = 4,
  parameter int unsigned SATURATE = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 en,
  input  logic                 up,
  input  logic                 load,
  input  logic [4*BCD_NUM-1:0] load_bcds,
  output logic [4*BCD_NUM-1:0] bcds,
  output logic                 ovf,
  output logic                 unf,
  output logic                 load_err,
  output logic                 is_zero
);

  logic                 load_ok;
  logic                 all_nine;
  logic                 all_zero;
  logic                 carry;
  logic [4*BCD_NUM-1:0] step_bcds;

  always_comb begin
    load_ok  = 1'b1;
    all_nine = 1'b1;
    all_zero = 1'b1;
    for (int i = 0; i < BCD_NUM; i++) begin
      if (load_bcds[4*i +: 4] > 4'd9) load_ok  = 1'b0;
      if (bcds[4*i +: 4] != 4'd9)     all_nine = 1'b0;
      if (bcds[4*i +: 4] != 4'd0)     all_zero = 1'b0;
    end
  end

  // Carry/borrow ripples from digit 0 upward; a wrap at the limits falls out naturally.
  always_comb begin
    step_bcds = bcds;
    carry     = 1'b1;
    for (int i = 0; i < BCD_NUM; i++) begin
      if (carry) begin
        if (up) begin
          if (bcds[4*i +: 4] == 4'd9) begin
            step_bcds[4*i +: 4] = 4'd0;
          end else begin
            step_bcds[4*i +: 4] = bcds[4*i +: 4] + 4'd1;
            carry               = 1'b0;
          end
        end else begin
          if (bcds[4*i +: 4] == 4'd0) begin
            step_bcds[4*i +: 4] = 4'd9;
          end else begin
            step_bcds[4*i +: 4] = bcds[4*i +: 4] - 4'd1;
            carry               = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bcds     <= '0;
      ovf      <= 1'b0;
      unf      <= 1'b0;
      load_err <= 1'b0;
    end else begin
      ovf      <= 1'b0;
      unf      <= 1'b0;
      load_err <= 1'b0;
      if (clear) begin
        bcds <= '0;
      end else if (load) begin
        if (load_ok) bcds     <= load_bcds;
        else         load_err <= 1'b1;
      end else if (en) begin
        if (up && all_nine) begin
          ovf <= 1'b1;
          if (SATURATE == 0) bcds <= step_bcds;
        end else if (!up && all_zero) begin
          unf <= 1'b1;
          if (SATURATE == 0) bcds <= step_bcds;
        end else begin
          bcds <= step_bcds;
        end
      end
    end
  end

  assign is_zero = all_zero;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Bench for bcd_updown_counter: a wrapping and a saturating 3-digit instance share stimulus;
// directed vectors, a reset-during-count sequence, then random stimulus against an integer model.
module tb_bcd_updown_counter;

  localparam int unsigned N    = 3;
  localparam int          MAXV = 999;

  logic          clk = 1'b0;
  logic          reset, clear, en, up, load;
  logic [11:0]   load_bcds;
  logic [11:0]   bcds_w, bcds_s;
  logic          ovf_w, unf_w, le_w, zero_w;
  logic          ovf_s, unf_s, le_s, zero_s;

  int checks = 0;
  int errors = 0;

  // Model state: plain integers for each instance
  int mv_w, mv_s;
  bit mo_w, mu_w, ml_w, mo_s, mu_s, ml_s;

  always #5 clk = ~clk;

  bcd_updown_counter #(.BCD_NUM(N), .SATURATE(0)) u_wrap (
    .clk(clk), .reset(reset), .clear(clear), .en(en), .up(up), .load(load),
    .load_bcds(load_bcds), .bcds(bcds_w), .ovf(ovf_w), .unf(unf_w), .load_err(le_w),
    .is_zero(zero_w)
  );

  bcd_updown_counter #(.BCD_NUM(N), .SATURATE(1)) u_sat (
    .clk(clk), .reset(reset), .clear(clear), .en(en), .up(up), .load(load),
    .load_bcds(load_bcds), .bcds(bcds_s), .ovf(ovf_s), .unf(unf_s), .load_err(le_s),
    .is_zero(zero_s)
  );

  typedef struct {
    string       name;
    bit          r, c, l;
    logic [11:0] ldv;
    bit          e, u;
    logic [15:0] exp_w;  // {bcds, ovf, unf, load_err, is_zero}
    logic [15:0] exp_s;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input string name, input bit r, input bit c, input bit l,
                              input logic [11:0] ldv, input bit e, input bit u,
                              input logic [15:0] exp_w, input logic [15:0] exp_s);
    vec_t v;
    v.name = name; v.r = r; v.c = c; v.l = l; v.ldv = ldv; v.e = e; v.u = u;
    v.exp_w = exp_w; v.exp_s = exp_s;
    return v;
  endfunction

  function automatic int bcd2int(input logic [11:0] b);
    return int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [11:0] int2bcd(input int v);
    logic [3:0] d2, d1, d0;
    d2 = 4'(v / 100);
    d1 = 4'((v / 10) % 10);
    d0 = 4'(v % 10);
    return {d2, d1, d0};
  endfunction

  function automatic void model_next(input bit sat, input int cur, input bit r, input bit c,
                                     input bit l, input logic [11:0] ldv, input bit e,
                                     input bit u, output int nv, output bit o,
                                     output bit un, output bit le);
    nv = cur; o = 1'b0; un = 1'b0; le = 1'b0;
    if (r || c) begin
      nv = 0;
    end else if (l) begin
      if (ldv[11:8] <= 4'd9 && ldv[7:4] <= 4'd9 && ldv[3:0] <= 4'd9) nv = bcd2int(ldv);
      else le = 1'b1;
    end else if (e) begin
      if (u) begin
        if (cur == MAXV) begin o = 1'b1; if (!sat) nv = 0; end
        else nv = cur + 1;
      end else begin
        if (cur == 0) begin un = 1'b1; if (!sat) nv = MAXV; end
        else nv = cur - 1;
      end
    end
  endfunction

  function automatic logic [15:0] model_pack(input int v, input bit o, input bit u, input bit l);
    return {int2bcd(v), o, u, l, (v == 0)};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got bcds=%03h flags(ovf,unf,lerr,zero)=%04b, want bcds=%03h flags=%04b",
               name, act[15:4], act[3:0], exp[15:4], exp[3:0]);
    end
  endtask

  // Drive one cycle of inputs, advance the model, and sample #1 after the edge.
  task automatic cycle(input bit r, input bit c, input bit l, input logic [11:0] ldv,
                       input bit e, input bit u);
    int nw, ns;
    @(negedge clk);
    reset = r; clear = c; load = l; load_bcds = ldv; en = e; up = u;
    model_next(1'b0, mv_w, r, c, l, ldv, e, u, nw, mo_w, mu_w, ml_w);
    model_next(1'b1, mv_s, r, c, l, ldv, e, u, ns, mo_s, mu_s, ml_s);
    mv_w = nw; mv_s = ns;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] act_w();
    return {bcds_w, ovf_w, unf_w, le_w, zero_w};
  endfunction

  function automatic logic [15:0] act_s();
    return {bcds_s, ovf_s, unf_s, le_s, zero_s};
  endfunction

  task automatic check_model(input string name);
    check({name, "_wrap"}, act_w(), model_pack(mv_w, mo_w, mu_w, ml_w));
    check({name, "_sat"},  act_s(), model_pack(mv_s, mo_s, mu_s, ml_s));
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; en = 1'b0; up = 1'b0; load = 1'b0; load_bcds = '0;
    mv_w = 0; mv_s = 0;

    //          name         r  c  l  ldv      e  u  exp_wrap   exp_sat
    tbl.push_back(mk("reset",     1, 0, 0, 12'h000, 0, 0, 16'h0001, 16'h0001));
    tbl.push_back(mk("ld999",     0, 0, 1, 12'h999, 0, 0, 16'h9990, 16'h9990));
    tbl.push_back(mk("ovf",       0, 0, 0, 12'h000, 1, 1, 16'h0009, 16'h9998));
    tbl.push_back(mk("ovf_gone",  0, 0, 0, 12'h000, 0, 0, 16'h0001, 16'h9990));
    tbl.push_back(mk("clear",     0, 1, 0, 12'h000, 0, 0, 16'h0001, 16'h0001));
    tbl.push_back(mk("unf",       0, 0, 0, 12'h000, 1, 0, 16'h9994, 16'h0005));
    tbl.push_back(mk("unf_gone",  0, 0, 0, 12'h000, 0, 0, 16'h9990, 16'h0001));
    tbl.push_back(mk("ld109",     0, 0, 1, 12'h109, 0, 0, 16'h1090, 16'h1090));
    tbl.push_back(mk("up110",     0, 0, 0, 12'h000, 1, 1, 16'h1100, 16'h1100));
    tbl.push_back(mk("dn109",     0, 0, 0, 12'h000, 1, 0, 16'h1090, 16'h1090));
    tbl.push_back(mk("dn108",     0, 0, 0, 12'h000, 1, 0, 16'h1080, 16'h1080));
    tbl.push_back(mk("ld100",     0, 0, 1, 12'h100, 0, 0, 16'h1000, 16'h1000));
    tbl.push_back(mk("dn099",     0, 0, 0, 12'h000, 1, 0, 16'h0990, 16'h0990));
    tbl.push_back(mk("ld1A5",     0, 0, 1, 12'h1A5, 0, 0, 16'h0992, 16'h0992));
    tbl.push_back(mk("lerr_gone", 0, 0, 0, 12'h000, 0, 0, 16'h0990, 16'h0990));
    tbl.push_back(mk("ld405",     0, 0, 1, 12'h405, 0, 0, 16'h4050, 16'h4050));
    tbl.push_back(mk("ld123",     0, 0, 1, 12'h123, 0, 0, 16'h1230, 16'h1230));
    tbl.push_back(mk("clr_ld_en", 0, 1, 1, 12'h777, 1, 1, 16'h0001, 16'h0001));
    tbl.push_back(mk("ld_en",     0, 0, 1, 12'h777, 1, 1, 16'h7770, 16'h7770));
    tbl.push_back(mk("rst_all",   1, 1, 1, 12'h555, 1, 1, 16'h0001, 16'h0001));

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].r, tbl[i].c, tbl[i].l, tbl[i].ldv, tbl[i].e, tbl[i].u);
      check({tbl[i].name, "_wrap"}, act_w(), tbl[i].exp_w);
      check({tbl[i].name, "_sat"},  act_s(), tbl[i].exp_s);
    end

    // Reset lands mid-way through 20 consecutive up-steps; counting restarts from zero.
    for (int i = 0; i < 20; i++) begin
      cycle((i == 14), 1'b0, 1'b0, 12'h000, 1'b1, 1'b1);
      if (i == 13) check("pre_reset_014", act_w(), 16'h0140);
      if (i == 14) check("mid_reset_000", act_w(), 16'h0001);
      check_model($sformatf("run%0d", i));
    end
    check("after_reset_005_wrap", act_w(), 16'h0050);
    check("after_reset_005_sat",  act_s(), 16'h0050);

    // Random stimulus; loads favour the limits so wrap/saturate paths get exercised.
    for (int i = 0; i < 400; i++) begin
      bit          r, c, l, e, u;
      logic [11:0] ldv;
      int          sel;
      r = ($urandom_range(0, 49) == 0);
      c = ($urandom_range(0, 19) == 0);
      l = ($urandom_range(0, 5) == 0);
      e = ($urandom_range(0, 2) != 0);
      u = $urandom_range(0, 1) == 1;
      sel = $urandom_range(0, 3);
      if (sel == 0)      ldv = 12'h999;
      else if (sel == 1) ldv = 12'h001;
      else               ldv = 12'($urandom_range(0, 4095));
      cycle(r, c, l, ldv, e, u);
      check_model($sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
